// File: rtl/score_counter.sv
// BCD score counter: one INCREMENT per enable rising edge, rippled one digit per cycle,
// then re-encoded to seven-segment bytes. Define SCORE_WRAP_EN to wrap instead of saturating at all-9s.
module score_counter #(
  parameter int unsigned SCORE_DIGITS = 3,
  parameter int unsigned INCREMENT    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  output logic                      ready,
  output logic [8*SCORE_DIGITS-1:0] display,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic                      overflow
);

  localparam int unsigned IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INC    = 2'd1,
    ENCODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [3:0]                carry_q, carry_d;
  logic [4*SCORE_DIGITS-1:0] digits_q, digits_d;
  logic [8*SCORE_DIGITS-1:0] display_q, display_d;
  logic                      overflow_q, overflow_d;
  logic                      ready_q, ready_d;
  logic                      enable_q;
  logic                      start_c;
  logic [4:0]                sum_c;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h40;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= '0;
      digits_q   <= '0;
      display_q  <= {SCORE_DIGITS{8'h3F}};
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      digits_q   <= digits_d;
      display_q  <= display_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      enable_q   <= enable;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    digits_d   = digits_q;
    display_d  = display_q;
    overflow_d = overflow_q;
    start_c    = enable & ~enable_q;
    sum_c      = 5'(digits_q[4*idx_q +: 4]) + 5'(carry_q);

    case (state_q)
      IDLE, DONE: begin
        // clear wins over a simultaneous start
        if (clear) begin
          digits_d   = '0;
          overflow_d = 1'b0;
          idx_d      = '0;
          state_d    = ENCODE;
        end else if ((state_q == IDLE) && start_c) begin
          idx_d   = '0;
          carry_d = 4'(INCREMENT);
          state_d = INC;
        end else if ((state_q == DONE) && !enable) begin
          state_d = IDLE;
        end
      end
      INC: begin
        if (sum_c > 5'd9) begin
          digits_d[4*idx_q +: 4] = 4'(sum_c - 5'd10);
          carry_d                = 4'd1;
        end else begin
          digits_d[4*idx_q +: 4] = sum_c[3:0];
          carry_d                = 4'd0;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ENCODE;
          if (sum_c > 5'd9) begin
`ifdef SCORE_WRAP_EN
            overflow_d = 1'b1;
`else
            overflow_d = 1'b1;
            digits_d   = {SCORE_DIGITS{4'h9}};
`endif
          end
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      ENCODE: begin
        display_d[8*idx_q +: 8] = seg7(digits_q[4*idx_q +: 4]);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  assign ready     = ready_q;
  assign display   = display_q;
  assign score_bcd = digits_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_counter.sv
// Randomized bench for score_counter: two instances (3 digits/+1 and 2 digits/+7) share
// stimulus and are checked against an integer score model.
module tb_score_counter;

  localparam int unsigned D1 = 3;
  localparam int unsigned I1 = 1;
  localparam int unsigned D2 = 2;
  localparam int unsigned I2 = 7;
`ifdef SCORE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic clock = 1'b0;
  logic reset, enable, clear;
  logic            ready1, ovf1, ready2, ovf2;
  logic [8*D1-1:0] disp1;
  logic [4*D1-1:0] score1;
  logic [8*D2-1:0] disp2;
  logic [4*D2-1:0] score2;

  int total = 0;
  int bad   = 0;
  int m1, m2;
  bit mo1, mo2;

  score_counter #(.SCORE_DIGITS(D1), .INCREMENT(I1)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ready(ready1), .display(disp1), .score_bcd(score1), .overflow(ovf1));

  score_counter #(.SCORE_DIGITS(D2), .INCREMENT(I2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ready(ready2), .display(disp2), .score_bcd(score2), .overflow(ovf2));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [95:0] bcd_of(input int s, input int digits);
    logic [95:0] r = '0;
    int v = s;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [95:0] disp_of(input int s, input int digits);
    logic [95:0] r = '0;
    int v = s;
    for (int k = 0; k < digits; k++) begin
      r[8*k +: 8] = SEG[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  // Score arithmetic as the player sees it: add, then wrap or pin at all-9s past the top.
  task automatic model_add(inout int s, inout bit ov, input int inc, input int digits);
    int lim = pow10(digits);
    s = s + inc;
    if (s >= lim) begin
      ov = 1'b1;
      if (WRAP) s = s - lim;
      else      s = lim - 1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".score1"}, 96'(score1), bcd_of(m1, D1));
    check({tag, ".disp1"},  96'(disp1),  disp_of(m1, D1));
    check({tag, ".ovf1"},   96'(ovf1),   96'(mo1));
    check({tag, ".score2"}, 96'(score2), bcd_of(m2, D2));
    check({tag, ".disp2"},  96'(disp2),  disp_of(m2, D2));
    check({tag, ".ovf2"},   96'(ovf2),   96'(mo2));
  endtask

  // Counts low-ready cycles of each instance until both are ready again (bounded).
  task automatic wait_ready(output int lo1, output int lo2);
    int n = 0;
    lo1 = 0;
    lo2 = 0;
    do begin
      @(negedge clock);
      clear = 1'b0;
      if (!ready1) lo1++;
      if (!ready2) lo2++;
      n++;
    end while ((!ready1 || !ready2) && n < 60);
  endtask

  task automatic pulse(input int hold, input int low);
    int lo1, lo2;
    enable = 1'b1;
    wait_ready(lo1, lo2);
    check("rdy_lo1", 96'(lo1), 96'(2*D1));
    check("rdy_lo2", 96'(lo2), 96'(2*D2));
    model_add(m1, mo1, I1, D1);
    model_add(m2, mo2, I2, D2);
    repeat (hold) @(negedge clock);
    check("rdy_done", 96'({ready1, ready2}), 96'(2'b11));
    enable = 1'b0;
    repeat (low) @(negedge clock);
  endtask

  task automatic clear_op(input bit with_en);
    int lo1, lo2;
    clear  = 1'b1;
    enable = with_en;
    wait_ready(lo1, lo2);
    check("clr_lo1", 96'(lo1), 96'(D1));
    check("clr_lo2", 96'(lo2), 96'(D2));
    m1 = 0; m2 = 0; mo1 = 1'b0; mo2 = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check_state("clear");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    m1 = 0; m2 = 0; mo1 = 1'b0; mo2 = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rdy", 96'({ready1, ready2}), 96'(2'b11));
    check_state("reset");
    reset = 1'b0;
    @(negedge clock);

    // first pulse: enable high 25 cycles in total
    pulse(25 - (2*D1 + 1), 5);
    check_state("first");
    for (int p = 0; p < 9; p++) pulse(25 - (2*D1 + 1), 5);
    check_state("ten");

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) == 0) clear_op(1'($urandom_range(0, 1)));
      else pulse($urandom_range(0, 6), $urandom_range(1, 4));
      check_state("rand");
    end

    // reset while digit 1 of a ripple is in flight
    enable = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    m1 = 0; m2 = 0; mo1 = 1'b0; mo2 = 1'b0;
    check("midrst_rdy", 96'({ready1, ready2}), 96'(2'b11));
    check_state("midrst");
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    pulse(2, 2);
    check_state("after_rst");

    // clear and enable rising together: clear wins, no increment
    clear_op(1'b1);

    for (int p = 0; p < 999; p++) pulse(0, 1);
    check_state("at999");
    pulse(1, 2);
    check_state("past999");
    pulse(1, 2);
    check_state("past999b");

    clear_op(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
